// File: rtl/alu_result_stage.sv
// Purpose : registered result/flag stage after the CLA adder; 2-entry skid FIFO with Z/N/C/V per entry.
// Latency : 1 cycle; an entry pushed into an empty stage is on the outputs right after its capture edge.
// Backpres: in_ready = (count != 2) from registered state only; the head entry is held while out_ready=0.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake; sum/cout/a_msb/b_msb are the adder outputs and operand sign bits
//   out_valid/out_ready downstream handshake; result and flag_z/n/c/v present the head entry
// Optional (macro ALU_STICKY_OVF_EN): clr_sticky input, sticky_v output (sticky signed-overflow flag).
module alu_result_stage #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] sum,
    input  logic         cout,
    input  logic         a_msb,
    input  logic         b_msb,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         flag_z,
    output logic         flag_n,
    output logic         flag_c,
    output logic         flag_v
`ifdef ALU_STICKY_OVF_EN
    ,
    input  logic         clr_sticky,
    output logic         sticky_v
`endif
);

    typedef struct packed {
        logic [N-1:0] sum;
        logic         z;
        logic         n;
        logic         c;
        logic         v;
    } entry_t;

    entry_t     mem [2];
    logic       head;
    logic       tail;
    logic [1:0] count;

    // Output register mirrors the head entry; it is only reloaded when the
    // stage will be non-empty, so it keeps the last popped entry when empty.
    entry_t     out_q;

    entry_t     in_entry;
    entry_t     head_entry_next;
    logic       push;
    logic       pop;
    logic       next_head;
    logic [1:0] next_count;

    always_comb begin
        in_entry.sum = sum;
        in_entry.z   = (sum == '0);
        in_entry.n   = sum[N-1];
        in_entry.c   = cout;
        // Signed overflow: operands share a sign and the sum's sign differs.
        in_entry.v   = (a_msb == b_msb) && (sum[N-1] != a_msb);
    end

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        next_head  = pop ? ~head : head;
        next_count = count;
        case ({push, pop})
            2'b10:   next_count = count + 2'd1;
            2'b01:   next_count = count - 2'd1;
            default: next_count = count;
        endcase
        // The entry being written this cycle may itself become the new head
        // (empty push, or push+pop at count 1), so bypass it in that case.
        if (push && (tail == next_head)) begin
            head_entry_next = in_entry;
        end else begin
            head_entry_next = mem[next_head];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            head   <= 1'b0;
            tail   <= 1'b0;
            count  <= 2'd0;
            out_q  <= '0;
        end else begin
            if (push) begin
                mem[tail] <= in_entry;
                tail      <= ~tail;
            end
            head  <= next_head;
            count <= next_count;
            if (next_count != 2'd0) begin
                out_q <= head_entry_next;
            end
        end
    end

    assign result = out_q.sum;
    assign flag_z = out_q.z;
    assign flag_n = out_q.n;
    assign flag_c = out_q.c;
    assign flag_v = out_q.v;

`ifdef ALU_STICKY_OVF_EN
    // A popped overflow takes priority over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_v <= 1'b0;
        end else if (pop && out_q.v) begin
            sticky_v <= 1'b1;
        end else if (clr_sticky) begin
            sticky_v <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Purpose : directed self-checking bench for alu_result_stage (N=8).
// Latency : checks are taken 1 time unit after each rising edge.
// Backpres: exercises full-stage stall, push+pop at count 1 and mid-stream reset.
module tb_alu_result_stage;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         a_msb;
    logic         b_msb;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         flag_z;
    logic         flag_n;
    logic         flag_c;
    logic         flag_v;
`ifdef ALU_STICKY_OVF_EN
    logic         clr_sticky;
    logic         sticky_v;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_result_stage #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .cout      (cout),
        .a_msb     (a_msb),
        .b_msb     (b_msb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_c    (flag_c),
        .flag_v    (flag_v)
`ifdef ALU_STICKY_OVF_EN
        ,
        .clr_sticky(clr_sticky),
        .sticky_v  (sticky_v)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [N-1:0] s, input logic c, input logic a, input logic b);
        in_valid = v;
        sum      = s;
        cout     = c;
        a_msb    = a;
        b_msb    = b;
    endtask

    function automatic logic [3:0] flags();
        return {flag_z, flag_n, flag_c, flag_v};
    endfunction

    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
`ifdef ALU_STICKY_OVF_EN
        clr_sticky = 1'b0;
`endif
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready",  in_ready,  1);
        check("rst_result",    result,    0);
        check("rst_flags",     flags(),   0);
`ifdef ALU_STICKY_OVF_EN
        check("rst_sticky",    sticky_v,  0);
`endif

        // Overflow: 0x7F + 0x01 = 0x80
        out_ready = 1'b1;
        drive(1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
        step();
        check("ovf_out_valid", out_valid, 1);
        check("ovf_result",    result,    8'h80);
        check("ovf_flags",     flags(),   4'b0101);

        // Wrap: 0xFF + 0x01 = 0x00 carry out; pushed while 0x80 pops
        drive(1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
        step();
        check("wrap_out_valid", out_valid, 1);
        check("wrap_result",    result,    8'h00);
        check("wrap_flags",     flags(),   4'b1010);
`ifdef ALU_STICKY_OVF_EN
        check("sticky_set_by_ovf_pop", sticky_v, 1);
`endif
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step();
        check("drain_out_valid", out_valid, 0);
        check("drain_hold_result", result, 8'h00);

        // Backpressure: three offers with out_ready low
        out_ready = 1'b0;
        drive(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        step();
        check("bp1_result",   result,   8'h11);
        check("bp1_in_ready", in_ready, 1);
        drive(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        step();
        check("bp2_in_ready", in_ready, 0);
        check("bp2_result",   result,   8'h11);
        drive(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        step();
        check("bp3_in_ready",  in_ready,  0);
        check("bp3_out_valid", out_valid, 1);
        check("bp3_result",    result,    8'h11);
        out_ready = 1'b1;
        step();
        check("bp_pop1_result",   result,   8'h22);
        check("bp_pop1_in_ready", in_ready, 1);
        step();
        check("bp_pop2_result",    result,    8'h33);
        check("bp_pop2_out_valid", out_valid, 1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step();
        check("bp_empty_out_valid", out_valid, 0);

        // Simultaneous push/pop at count 1
        out_ready = 1'b0;
        drive(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
        step();
        check("pp_head44", result, 8'h44);
        out_ready = 1'b1;
        drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        step();
        check("pp_head55",      result,    8'h55);
        check("pp_out_valid",   out_valid, 1);
        check("pp_in_ready",    in_ready,  1);

        // Fill to count 2, then reset mid-operation (in_valid high is ignored)
        out_ready = 1'b0;
        drive(1'b1, 8'h77, 1'b0, 1'b1, 1'b1);
        step();
        check("full_in_ready", in_ready, 0);
        rst = 1'b1;
        drive(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
        out_ready = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b0;
        check("mrst_out_valid", out_valid, 0);
        check("mrst_in_ready",  in_ready,  1);
        check("mrst_result",    result,    0);
        check("mrst_flags",     flags(),   0);
`ifdef ALU_STICKY_OVF_EN
        check("mrst_sticky",    sticky_v,  0);
`endif
        drive(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
        step();
        check("post_rst_result",    result,    8'h66);
        check("post_rst_out_valid", out_valid, 1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        step();
        check("post_rst_alone", out_valid, 0);

`ifdef ALU_STICKY_OVF_EN
        // Pop a V=1 entry
        drive(1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step();
        check("sticky_set", sticky_v, 1);
        // Later V=0 pop keeps it
        drive(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step();
        check("sticky_hold", sticky_v, 1);
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        check("sticky_clr", sticky_v, 0);
        // V=1 pop together with clear: set wins
        out_ready = 1'b0;
        drive(1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        out_ready  = 1'b1;
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        check("sticky_set_wins", sticky_v, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
